// File: rtl/regwr_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regwr_pkg;

  localparam int REG_AW   = 5;
  localparam int REG_DW   = 32;
  localparam int REG_ZERO = 0;

  // One writeback request: destination register and the value to write.
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// Combinational round-robin priority rotation: the first set bit of req at
// or after ptr (wrapping modulo N) wins. Generic so it can be reused for
// other shared ports.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found_s;
  int   pos_s;

  // Walk the requesters starting at ptr and grant the first valid one.
  always_comb begin
    gnt     = {N{1'b0}};
    idx     = {IW{1'b0}};
    found_s = 1'b0;
    pos_s   = 0;
    for (int k = 0; k < N; k++) begin
      pos_s = (int'(ptr) + k) % N;
      if (!found_s && req[pos_s]) begin
        gnt[pos_s] = 1'b1;
        idx        = IW'(pos_s);
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single reg_file write port (A3/WD3/WE3)
// between NREQ writeback requesters. One write accepted per cycle; the
// write port is registered. Writes to r0 complete the handshake but never
// raise wr_en. rd_invalid mirrors wr_en because reg_file read ports float
// while WE3 is high.
// Optional macro REGWR_BYPASS_EN adds two address comparators that expose
// the in-flight write value to issue logic.
module regfile_wr_arbiter
  import regwr_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [DW-1:0]     wr_data,
  output logic              rd_invalid,
  output logic [2:0]        grant_idx
`ifdef REGWR_BYPASS_EN
  ,
  input  logic [AW-1:0]     byp_addr_a,
  input  logic [AW-1:0]     byp_addr_b,
  output logic              byp_hit_a,
  output logic              byp_hit_b,
  output logic [DW-1:0]     byp_data
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] gnt_s;
  logic [PW-1:0]   gidx_s;
  logic [PW-1:0]   ptr_nxt_s;
  logic            any_s;
  logic [AW-1:0]   sel_addr_s;
  logic [DW-1:0]   sel_data_s;

  logic [PW-1:0]   rr_ptr_r;
  logic            wr_en_r;
  logic [AW-1:0]   wr_addr_r;
  logic [DW-1:0]   wr_data_r;
  logic [2:0]      grant_idx_r;

  rr_arbiter #(.N(NREQ), .IW(PW)) u_rr_arbiter (
    .req (req_valid),
    .ptr (rr_ptr_r),
    .gnt (gnt_s),
    .idx (gidx_s)
  );

  // Grant is suppressed during reset; it never depends on wr_en.
  assign req_ready = reset ? {NREQ{1'b0}} : gnt_s;
  assign any_s     = |req_ready;

  // Select the granted request and the pointer that follows it.
  always_comb begin
    sel_addr_s = req_addr[gidx_s*AW +: AW];
    sel_data_s = req_data[gidx_s*DW +: DW];
    if (int'(gidx_s) == NREQ - 1) begin
      ptr_nxt_s = {PW{1'b0}};
    end else begin
      ptr_nxt_s = gidx_s + PW'(1);
    end
  end

  // Register the accepted write and advance the round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r    <= {PW{1'b0}};
      wr_en_r     <= 1'b0;
      wr_addr_r   <= {AW{1'b0}};
      wr_data_r   <= {DW{1'b0}};
      grant_idx_r <= 3'd0;
    end else if (any_s) begin
      rr_ptr_r    <= ptr_nxt_s;
      wr_en_r     <= (sel_addr_s != AW'(REG_ZERO));
      wr_addr_r   <= sel_addr_s;
      wr_data_r   <= sel_data_s;
      grant_idx_r <= 3'(gidx_s);
    end else begin
      wr_en_r     <= 1'b0;
    end
  end

  assign wr_en      = wr_en_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign rd_invalid = wr_en_r;
  assign grant_idx  = grant_idx_r;

`ifdef REGWR_BYPASS_EN
  assign byp_hit_a = wr_en_r & (wr_addr_r == byp_addr_a) & (byp_addr_a != AW'(REG_ZERO));
  assign byp_hit_b = wr_en_r & (wr_addr_r == byp_addr_b) & (byp_addr_b != AW'(REG_ZERO));
  assign byp_data  = wr_data_r;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter with a reference model of the
// arbitration rules and a model register file.
module tb_regfile_wr_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic               rd_invalid;
  logic [2:0]         grant_idx;
`ifdef REGWR_BYPASS_EN
  logic [AW-1:0]      byp_addr_a = '0;
  logic [AW-1:0]      byp_addr_b = '0;
  logic               byp_hit_a;
  logic               byp_hit_b;
  logic [DW-1:0]      byp_data;
`endif

  regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_invalid (rd_invalid),
    .grant_idx  (grant_idx)
`ifdef REGWR_BYPASS_EN
    ,
    .byp_addr_a (byp_addr_a),
    .byp_addr_b (byp_addr_b),
    .byp_hit_a  (byp_hit_a),
    .byp_hit_b  (byp_hit_b),
    .byp_data   (byp_data)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int            m_ptr;
  logic          m_wr_en;
  logic [AW-1:0] m_wr_addr;
  logic [DW-1:0] m_wr_data;
  logic [2:0]    m_gidx;
  logic [DW-1:0] rf [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner is the valid requester with the smallest forward distance from the pointer.
  function automatic int model_grant();
    int best  = -1;
    int bestd = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        int d = (i - m_ptr + NREQ) % NREQ;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]        = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // One clock: check the combinational grant, advance the model at the edge, check registered outputs.
  task automatic cycle(input logic rst);
    int g;
    logic [NREQ-1:0] exp_ready;
    reset = rst;
    #1;
    g = rst ? -1 : model_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    @(posedge clk);
    if (m_wr_en === 1'b1) rf[m_wr_addr] = m_wr_data;
    if (rst) begin
      m_ptr = 0; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0; m_gidx = 3'd0;
    end else if (g >= 0) begin
      m_wr_addr = req_addr[g*AW +: AW];
      m_wr_data = req_data[g*DW +: DW];
      m_wr_en   = (m_wr_addr != 5'd0);
      m_gidx    = 3'(g);
      m_ptr     = (g + 1) % NREQ;
    end else begin
      m_wr_en = 1'b0;
    end
    #1;
    check("wr_en", 64'(wr_en), 64'(m_wr_en));
    check("rd_invalid", 64'(rd_invalid), 64'(m_wr_en));
    check("wr_addr", 64'(wr_addr), 64'(m_wr_addr));
    check("wr_data", 64'(wr_data), 64'(m_wr_data));
    check("grant_idx", 64'(grant_idx), 64'(m_gidx));
`ifdef REGWR_BYPASS_EN
    check("byp_hit_a", 64'(byp_hit_a), 64'(m_wr_en && m_wr_addr == byp_addr_a && byp_addr_a != 5'd0));
    check("byp_hit_b", 64'(byp_hit_b), 64'(m_wr_en && m_wr_addr == byp_addr_b && byp_addr_b != 5'd0));
    check("byp_data", 64'(byp_data), 64'(m_wr_data));
`endif
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 5'd0, 32'd0);
  endtask

  logic [AW-1:0] seq_addr [6];

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    m_ptr = 0; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0; m_gidx = 3'd0;
    reset = 1'b1;
    clear_reqs();
    @(negedge clk);

    // Reset, then idle
    cycle(1'b1);
    cycle(1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0);
    check("idle_wr_en", 64'(wr_en), 64'd0);

    // Single write from requester 0
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    cycle(1'b0);
    check("single_wr_en", 64'(wr_en), 64'd1);
    check("single_wr_addr", 64'(wr_addr), 64'd5);
    check("single_wr_data", 64'(wr_data), 64'hDEADBEEF);
    clear_reqs();
    cycle(1'b0);
    check("single_rf5", 64'(rf[5]), 64'hDEADBEEF);

    // All three continuously valid: strict rotation from pointer 0
    cycle(1'b1);
    set_req(0, 1'b1, 5'd1, 32'h11);
    set_req(1, 1'b1, 5'd2, 32'h22);
    set_req(2, 1'b1, 5'd3, 32'h33);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0);
      seq_addr[i] = wr_addr;
      check("rot_grant_idx", 64'(grant_idx), 64'(i % 3));
    end
    check("rot_addr0", 64'(seq_addr[0]), 64'd1);
    check("rot_addr2", 64'(seq_addr[2]), 64'd3);
    check("rot_addr4", 64'(seq_addr[4]), 64'd2);
    clear_reqs();

    // Write to r0 is accepted but suppressed
    set_req(1, 1'b1, 5'd0, 32'h1234);
    cycle(1'b0);
    check("r0_wr_en", 64'(wr_en), 64'd0);
    check("r0_grant_idx", 64'(grant_idx), 64'd1);
    clear_reqs();
    cycle(1'b0);

    // Same address from two requesters: round-robin order, last writer wins
    cycle(1'b1);
    set_req(0, 1'b1, 5'd7, 32'hA);
    set_req(2, 1'b1, 5'd7, 32'hB);
    cycle(1'b0);
    check("same_first_data", 64'(wr_data), 64'hA);
    set_req(0, 1'b0, 5'd7, 32'hA);
    cycle(1'b0);
    check("same_second_data", 64'(wr_data), 64'hB);
    clear_reqs();
    cycle(1'b0);
    cycle(1'b0);
    check("same_rf7", 64'(rf[7]), 64'hB);
    check("rf0_zero", 64'(rf[0]), 64'd0);

    // Reset pulsed right after an accept still commits the write
    set_req(1, 1'b1, 5'd9, 32'h55);
`ifdef REGWR_BYPASS_EN
    byp_addr_a = 5'd9;
`endif
    cycle(1'b0);
`ifdef REGWR_BYPASS_EN
    check("byp_hit_lit", 64'(byp_hit_a), 64'd1);
    check("byp_data_lit", 64'(byp_data), 64'h55);
`endif
    clear_reqs();
    cycle(1'b1);
    check("rst_rf9", 64'(rf[9]), 64'h55);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    set_req(0, 1'b1, 5'd4, 32'h4);
    set_req(1, 1'b1, 5'd6, 32'h6);
    cycle(1'b0);
    check("rst_ptr_zero", 64'(grant_idx), 64'd0);
    clear_reqs();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
`ifdef REGWR_BYPASS_EN
      byp_addr_a = 5'($urandom_range(0, 7));
      byp_addr_b = 5'($urandom_range(0, 7));
`endif
      cycle(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
